// File: rtl/cnt_event_logger.sv
// Counter change logger: classifies changes of a sampled count and queues
// {kind, count, timestamp} entries in a small FIFO with drop accounting.
module cnt_event_logger #(
    parameter int CNT_W = 6,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CNT_W-1:0]         in_cnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [CNT_W-1:0]         out_cnt,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 2 + CNT_W + TS_W;

    typedef enum logic [1:0] {
        K_FIRST = 2'b00,
        K_INC   = 2'b01,
        K_WRAP  = 2'b10,
        K_JUMP  = 2'b11
    } kind_t;

    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] prev;
    logic             prev_vld;
    kind_t            kind;
    logic             evt;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_comb begin
        kind = K_JUMP;
        if (!prev_vld)
            kind = K_FIRST;
        else if (prev == '1 && in_cnt == '0)
            kind = K_WRAP;
        else if (in_cnt == prev + CNT_W'(1))
            kind = K_INC;
    end

    assign evt       = in_valid && (!prev_vld || in_cnt != prev);
    assign full      = (level == LW'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = evt && (!full || pop);
    assign drop      = evt && full && !pop;

    assign {out_kind, out_cnt, out_ts} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            prev     <= '0;
            prev_vld <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (in_valid) begin
                prev     <= in_cnt;
                prev_vld <= 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= {kind, in_cnt, ts};
    end

endmodule

// File: tb/tb_cnt_event_logger.sv
// Self-checking bench for cnt_event_logger: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_cnt_event_logger;

    localparam int CNT_W = 6;
    localparam int TS_W  = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int TMOD  = 1 << TS_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [CNT_W-1:0] in_cnt;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_kind;
    logic [CNT_W-1:0] out_cnt;
    logic [TS_W-1:0]  out_ts;
    logic [LW-1:0]    level;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    cnt_event_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cnt(in_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_cnt(out_cnt), .out_ts(out_ts), .level(level), .drop_cnt(drop_cnt)
    );

    typedef struct {
        int kind;
        int cnt;
        int ts;
    } ent_t;

    ent_t q[$];
    int   m_ts   = 0;
    int   m_prev = 0;
    bit   m_pv   = 0;
    int   m_drop = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input int c);
        if (!m_pv) return 0;
        if (m_prev == CMAX && c == 0) return 2;
        if (c == m_prev + 1) return 1;
        return 3;
    endfunction

    task automatic model_edge(input bit r, input bit v, input int c, input bit rdy);
        bit   was_full;
        bit   p;
        bit   e;
        ent_t en;
        if (r) begin
            m_ts = 0; m_prev = 0; m_pv = 0; m_drop = 0;
            q.delete();
            return;
        end
        e = v && (!m_pv || c != m_prev);
        was_full = (q.size() == DEPTH);
        p = (q.size() != 0) && rdy;
        if (e) begin
            en.kind = classify(c);
            en.cnt  = c;
            en.ts   = m_ts;
        end
        if (p) void'(q.pop_front());
        if (e) begin
            if (!was_full || p) q.push_back(en);
            else if (m_drop < 255) m_drop++;
        end
        if (v) begin
            m_prev = c;
            m_pv   = 1;
        end
        m_ts = (m_ts + 1) % TMOD;
    endtask

    task automatic compare_all();
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (q.size() != 0) begin
            chk("out_kind", 32'(out_kind), 32'(q[0].kind));
            chk("out_cnt", 32'(out_cnt), 32'(q[0].cnt));
            chk("out_ts", 32'(out_ts), 32'(q[0].ts));
        end
    endtask

    task automatic cycle(input bit r, input bit v, input int c, input bit rdy);
        rst       = r;
        in_valid  = v;
        in_cnt    = CNT_W'(c);
        out_ready = rdy;
        @(posedge clk);
        model_edge(r, v, c, rdy);
        #1;
        compare_all();
    endtask

    initial begin
        int t0;
        int lastc;
        rst = 1'b1; in_valid = 1'b0; in_cnt = '0; out_ready = 1'b0;

        // reset then first sample
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        cycle(0, 1, 'h05, 0);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_kind", 32'(out_kind), 32'd0);
        chk("first_cnt", 32'(out_cnt), 32'h05);
        chk("first_ts", 32'(out_ts), 32'd0);
        chk("first_level", 32'(level), 32'd1);

        // INC / WRAP / INC with consecutive timestamps
        cycle(0, 1, 'h3E, 1);
        cycle(0, 1, 'h3F, 1);
        chk("inc_kind", 32'(out_kind), 32'd1);
        t0 = int'(out_ts);
        cycle(0, 1, 'h00, 1);
        chk("wrap_kind", 32'(out_kind), 32'd2);
        chk("wrap_ts", 32'(out_ts), 32'((t0 + 1) % TMOD));
        cycle(0, 1, 'h01, 1);
        chk("inc2_kind", 32'(out_kind), 32'd1);
        chk("inc2_ts", 32'(out_ts), 32'((t0 + 2) % TMOD));
        cycle(0, 0, 0, 1);

        // repeated value produces no entry
        cycle(1, 0, 0, 0);
        cycle(0, 1, 'h10, 0);
        cycle(0, 1, 'h10, 0);
        cycle(0, 1, 'h17, 0);
        chk("rep_level", 32'(level), 32'd2);
        cycle(0, 0, 0, 1);
        chk("jump_kind", 32'(out_kind), 32'd3);
        chk("jump_cnt", 32'(out_cnt), 32'h17);

        // overflow with drops, then pop+push while full
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) cycle(0, 1, i, 0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_head", 32'(out_cnt), 32'd1);
        cycle(0, 1, 6, 0);
        chk("ovf_prev", 32'(drop_cnt), 32'd2);
        cycle(0, 1, 9, 1);
        chk("full_pp_level", 32'(level), 32'd4);
        chk("full_pp_drop", 32'(drop_cnt), 32'd2);
        chk("full_pp_head", 32'(out_cnt), 32'd2);

        // reset beats a concurrent event
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 20 + i, 0);
        chk("pre_rst_level", 32'(level), 32'd3);
        cycle(1, 1, 30, 0);
        chk("rst_pri_level", 32'(level), 32'd0);
        chk("rst_pri_valid", 32'(out_valid), 32'd0);
        chk("rst_pri_drop", 32'(drop_cnt), 32'd0);
        cycle(0, 1, 30, 0);
        chk("post_rst_kind", 32'(out_kind), 32'd0);

        // drop counter saturation
        for (int i = 0; i < 300; i++) cycle(0, 1, i % 2, 0);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // random traffic
        cycle(1, 0, 0, 0);
        lastc = 0;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            int c;
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       c = lastc;
                1:       c = (lastc + 1) % (CMAX + 1);
                2:       c = CMAX;
                3:       c = 0;
                default: c = int'($urandom_range(0, CMAX));
            endcase
            lastc = c;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                  c, ($urandom_range(0, 9) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
